matrix_c_reader: RTL and testbench
==================================

# matrix_c_reader

Downstream readout stage for the 8x8 matrix multiplier.
- When the multiplier raises `done`, this block walks the 64-entry C result RAM in row-major order.
- It saturates each 19-bit signed result to a configurable output width.
- It streams the results out over a valid/ready interface at up to one word per cycle, with full backpressure support.
- It owns the C RAM read port only while the multiplier is finished.

## Interface
- `DIM`, 8: matrix dimension. C RAM depth is `DIM*DIM`.
- `C_WIDTH`, 19: signed width of a C RAM word.
- `OUT_WIDTH`, 16: signed width of the streamed result. Must be ≤ `C_WIDTH`.
- `ADDR_WIDTH`, 6: C RAM address width, equal to log2(`DIM*DIM`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `done`  in  1  multiplier done level. High = C RAM complete and stable.
- `c_rd_en`  out  1  high while this block drives the C RAM address. External address mux selects this block when high.
- `c_addr`  out  ADDR_WIDTH  C RAM read address.
- `c_data`  in  C_WIDTH  C RAM read data. Valid exactly 1 cycle after `c_addr` is presented.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid` & `out_ready`.
- `out_data`  out  OUT_WIDTH  saturated result.
- `out_sat`  out  1  `out_data` was clamped.
- `out_row`  out  3  row index, `c_addr[5:3]` of the word.
- `out_col`  out  3  column index, `c_addr[2:0]` of the word.
- `out_last`  out  1  high on entry 63.
- `frame_done`  out  1  one-cycle pulse after entry 63 is accepted.
- `busy`  out  1  high in any state other than IDLE and DONE.

## Operation
- Reset values: all outputs 0, state IDLE, read counter 0, FIFO empty.
- FSM states and transitions:
  - IDLE → STREAM on the rising edge of `done` (`done` & ~`done_q`). A `done` already high out of reset counts as a rising edge.
  - STREAM → DRAIN after read 63 is issued.
  - DRAIN → DONE when entry 63 is accepted. `frame_done` pulses in the first DONE cycle.
  - DONE → IDLE when `done` falls. The block re-arms for the next multiply.
- Abort: if `done` falls during STREAM or DRAIN:
  - next cycle: state IDLE, FIFO flushed, `out_valid` 0, `c_rd_en` 0;
  - no `frame_done` pulse.
- Read issue:
  - `c_rd_en` is 1 in STREAM and DRAIN.
  - A read of address `rd_cnt` is issued in a cycle when (fifo_count + inflight − pop) < 2, where pop = `out_valid` & `out_ready`.
  - `rd_cnt` increments on issue and stops at 63.
  - `c_addr` holds its last value when no read is issued.
- Buffering: returned data enters a 2-entry FIFO; `out_*` come from the FIFO head. The issue rule guarantees no overflow and no lost word.
- Saturation:
  - `c_data` > 2^(OUT_WIDTH−1)−1 → output 32767, `out_sat`=1.
  - `c_data` < −2^(OUT_WIDTH−1) → output −32768, `out_sat`=1.
  - Otherwise the value is truncated losslessly and `out_sat`=0.
  - Saturation is applied on FIFO write.
- Output ordering: strictly row-major, 0..63, no duplicates, no gaps.

## Timing
- Rising edge of `done` sampled at edge k:
  - `c_rd_en`=1 and `c_addr`=0 during cycle k+1;
  - `c_data` valid in cycle k+2;
  - `out_valid`=1 in cycle k+3.
- With `out_ready` held high, one word per cycle. Entry 63 appears in cycle k+66; `frame_done` pulses in cycle k+67.
- When `out_valid` is high, `out_data`, `out_sat`, `out_row`, `out_col` and `out_last` stay stable until accepted.
- `out_ready` has no combinational path to any output.
- Asynchronous reset asserted mid-frame clears all state immediately. After release the block waits in IDLE for a `done` rising edge, or for `done` sampled high per the rule above.

## Structure
- Shared package `matrix_pkg`:
  - `DIM`, `C_WIDTH`, `ADDR_WIDTH` constants;
  - the reader state encoding (IDLE, STREAM, DRAIN, DONE);
  - the saturation bound constants.
- Sub-module `result_skid_fifo`: a 2-entry, registered-output FIFO. Width is OUT_WIDTH+1+6 (data, sat, addr). It provides count, push, pop and flush.

## Test plan
- `done` rises, `out_ready`=1 constantly, C[i]=i → 64 beats. `out_data` sequence 0..63, first beat 3 cycles after the `done` edge, `out_last` only on beat 63, `frame_done` one cycle later.
- C[0]=131072, C[1]=−131072, C[2]=32767, C[3]=−32768 → `out_data` 32767, −32768, 32767, −32768 with `out_sat` 1, 1, 0, 0.
- `out_ready` toggling in a 1-high/2-low pattern → all 64 words delivered in order, no duplicates, outputs stable while stalled, `c_addr` never more than 2 ahead of the accepted count.
- `done` dropped after 20 accepted beats → `out_valid` 0 next cycle, no `frame_done`. A new `done` rise restarts at address 0.
- `reset` pulsed low at beat 40 → all outputs 0 immediately. After release, no output until the next `done` rise.
- Back-to-back frames: `done` falls in DONE then rises again → second full 64-beat frame, `frame_done` once per frame.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and types for the 8x8 matrix multiplier and its C readout stage.
package matrix_pkg;

    localparam int unsigned DIM           = 8;
    localparam int unsigned C_WIDTH       = 19;
    localparam int unsigned ADDR_WIDTH    = $clog2(DIM * DIM);
    localparam int unsigned IDX_WIDTH     = ADDR_WIDTH / 2;
    localparam int unsigned OUT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } reader_state_e;

    function automatic int sat_max(int unsigned width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(int unsigned width);
        return -(1 << (width - 1));
    endfunction

    localparam int SAT_MAX = sat_max(OUT_WIDTH_DEF);
    localparam int SAT_MIN = sat_min(OUT_WIDTH_DEF);

endpackage

// File: rtl/matrix_c_reader_if.sv
// C RAM read port plus the valid/ready result stream of the C readout stage.
interface matrix_c_reader_if #(
    parameter int unsigned C_WIDTH    = matrix_pkg::C_WIDTH,
    parameter int unsigned OUT_WIDTH  = matrix_pkg::OUT_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = matrix_pkg::ADDR_WIDTH
);
    logic                      c_rd_en;
    logic [ADDR_WIDTH-1:0]     c_addr;
    logic [C_WIDTH-1:0]        c_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_WIDTH-1:0]      out_data;
    logic                      out_sat;
    logic [ADDR_WIDTH/2-1:0]   out_row;
    logic [ADDR_WIDTH/2-1:0]   out_col;
    logic                      out_last;

    modport master (
        output c_rd_en, c_addr, out_valid, out_data, out_sat, out_row, out_col, out_last,
        input  c_data, out_ready
    );

    modport slave (
        input  c_rd_en, c_addr, out_valid, out_data, out_sat, out_row, out_col, out_last,
        output c_data, out_ready
    );
endinterface

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO whose head is held in a register, so readers see no comb path from pop.
module result_skid_fifo #(
    parameter int unsigned Width = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             valid,
    output logic [1:0]       count
);
    logic [Width-1:0] head_q, tail_q;
    logic [1:0]       count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (push && do_pop) begin
            if (count_q == 2'd1) begin
                head_q <= wdata;
            end else begin
                head_q <= tail_q;
                tail_q <= wdata;
            end
        end else if (push) begin
            if (count_q == 2'd0) head_q <= wdata;
            else                 tail_q <= wdata;
            count_q <= count_q + 2'd1;
        end else if (do_pop) begin
            head_q  <= tail_q;
            count_q <= count_q - 2'd1;
        end
    end

    assign rdata = head_q;
    assign valid = (count_q != 2'd0);
    assign count = count_q;
endmodule

// File: rtl/matrix_c_reader.sv
// Walks the C result RAM row-major after the multiplier finishes and streams saturated words.
module matrix_c_reader
    import matrix_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    output logic              frame_done,
    output logic              busy,
    matrix_c_reader_if.master bus
);
    localparam int unsigned FIFO_WIDTH = OUT_WIDTH + 1 + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DIM * DIM - 1);
    localparam logic signed [C_WIDTH-1:0] HI = C_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic signed [C_WIDTH-1:0] LO = C_WIDTH'(sat_min(OUT_WIDTH));

    reader_state_e         state_q, state_d;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  inflight_q;
    logic                  frame_done_q;

    logic                  rise, abort, issue, pop, reading;
    logic [2:0]            occ;
    logic signed [C_WIDTH-1:0] c_signed;
    logic [OUT_WIDTH-1:0]  sat_data;
    logic                  sat_flag;

    logic [FIFO_WIDTH-1:0] fifo_rdata;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic [ADDR_WIDTH-1:0] head_addr;

    assign rise    = done && !done_q;
    assign reading = (state_q == StStream) || (state_q == StDrain);
    assign abort   = reading && !done;
    assign pop     = fifo_valid && bus.out_ready;
    assign occ     = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    // Counting this cycle's pop keeps full rate with only two buffer slots.
    assign issue   = (state_q == StStream) && (occ < 3'd2);

    assign c_signed = signed'(bus.c_data);

    always_comb begin
        sat_flag = 1'b0;
        sat_data = c_signed[OUT_WIDTH-1:0];
        if (c_signed > HI) begin
            sat_flag = 1'b1;
            sat_data = HI[OUT_WIDTH-1:0];
        end else if (c_signed < LO) begin
            sat_flag = 1'b1;
            sat_data = LO[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        unique case (state_q)
            StIdle:   if (rise) state_d = StStream;
            StStream: begin
                if (!done) state_d = StIdle;
                else if (issue && rd_cnt_q == LAST_ADDR) state_d = StDrain;
            end
            StDrain: begin
                if (!done) state_d = StIdle;
                else if (pop && head_addr == LAST_ADDR) state_d = StDone;
            end
            StDone:   if (!done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (state_q != StStream) rd_cnt_d = '0;
        else if (issue && rd_cnt_q != LAST_ADDR) rd_cnt_d = rd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            done_q       <= 1'b0;
            rd_cnt_q     <= '0;
            last_addr_q  <= '0;
            inflight_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done;
            rd_cnt_q     <= rd_cnt_d;
            inflight_q   <= issue && !abort;
            frame_done_q <= (state_q == StDrain) && (state_d == StDone);
            if (issue) last_addr_q <= rd_cnt_q;
        end
    end

    // last_addr_q still names the word whose data is on c_data this cycle.
    result_skid_fifo #(
        .Width(FIFO_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (inflight_q),
        .pop  (pop),
        .flush(abort),
        .wdata({sat_data, sat_flag, last_addr_q}),
        .rdata(fifo_rdata),
        .valid(fifo_valid),
        .count(fifo_count)
    );

    assign head_addr     = fifo_rdata[ADDR_WIDTH-1:0];
    assign bus.out_data  = fifo_rdata[FIFO_WIDTH-1 -: OUT_WIDTH];
    assign bus.out_sat   = fifo_rdata[ADDR_WIDTH];
    assign bus.out_row   = head_addr[ADDR_WIDTH-1 -: IDX_WIDTH];
    assign bus.out_col   = head_addr[IDX_WIDTH-1:0];
    assign bus.out_last  = fifo_valid && (head_addr == LAST_ADDR);
    assign bus.out_valid = fifo_valid;
    assign bus.c_rd_en   = reading;
    assign bus.c_addr    = issue ? rd_cnt_q : last_addr_q;

    assign frame_done = frame_done_q;
    assign busy       = reading;
endmodule

// File: tb/tb_matrix_c_reader.sv
// Randomised self-checking bench for matrix_c_reader against a row-major saturation model.
module tb_matrix_c_reader;
    localparam int C_WIDTH    = 19;
    localparam int OUT_WIDTH  = 16;
    localparam int ADDR_WIDTH = 6;
    localparam int N          = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done = 1'b0;
    logic frame_done, busy;

    int mem[N];
    int checks = 0;
    int errors = 0;

    matrix_c_reader_if #(
        .C_WIDTH(C_WIDTH), .OUT_WIDTH(OUT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    matrix_c_reader #(
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .frame_done(frame_done),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // C RAM model: one cycle read latency.
    always @(posedge clk) bus.c_data <= C_WIDTH'(mem[bus.c_addr]);

    function automatic int exp_val(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit exp_sat(int v);
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic fill_mem(input int kind);
        for (int i = 0; i < N; i++) begin
            if (kind == 0) mem[i] = i;
            else if (i % 2 == 0) mem[i] = int'($urandom_range(0, 524287)) - 262144;
            else mem[i] = int'($urandom_range(0, 80000)) - 40000;
        end
        if (kind == 1) begin
            mem[0] = 131072;
            mem[1] = -131072;
            mem[2] = 32767;
            mem[3] = -32768;
        end
    endtask

    // mode: 0 ready high, 1 one-high/two-low, 2 random. Returns once stop_beat words are taken.
    task automatic run_frame(input string name, input int mode, input bit timing,
                             input int stop_beat);
        int beat = 0, n = 0, fd_cnt = 0, fd_n = -1, first_n = -1, last_n = -1;
        bit stalled = 0, rdy;
        logic [OUT_WIDTH+7:0] snap = '0, cur;
        @(negedge clk);
        done = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        done = 1'b1;
        while (n < 600) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) begin fd_cnt++; fd_n = n; end
            if (timing && n == 1) begin
                checks++;
                if (bus.c_rd_en !== 1'b1 || bus.c_addr !== 6'd0) begin
                    errors++;
                    $display("FAIL %s first_read: rd_en=%b addr=%0d expected rd_en=1 addr=0",
                             name, bus.c_rd_en, bus.c_addr);
                end
            end
            if (timing && n == 2) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_valid: out_valid=%b expected 0", name, bus.out_valid);
                end
            end
            cur = {bus.out_data, bus.out_sat, bus.out_row, bus.out_col, bus.out_last};
            if (stalled && bus.out_valid === 1'b1) begin
                checks++;
                if (cur !== snap) begin
                    errors++;
                    $display("FAIL %s stall_stable: got %h expected %h", name, cur, snap);
                end
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (n % 3 == 0);
            else rdy = 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            stalled = 0;
            if (bus.out_valid === 1'b1 && beat >= N) begin
                checks++;
                errors++;
                $display("FAIL %s extra_word: out_valid=1 after %0d words expected 0", name, beat);
            end else if (bus.out_valid === 1'b1) begin
                snap = cur;
                stalled = !rdy;
                if (rdy) begin
                    checks++;
                    if (int'($signed(bus.out_data)) !== exp_val(mem[beat]) ||
                        bus.out_sat !== exp_sat(mem[beat])) begin
                        errors++;
                        $display("FAIL %s data[%0d]: got %0d sat=%b expected %0d sat=%b", name,
                                 beat, $signed(bus.out_data), bus.out_sat, exp_val(mem[beat]),
                                 exp_sat(mem[beat]));
                    end
                    checks++;
                    if (bus.out_row !== 3'(beat / 8) || bus.out_col !== 3'(beat % 8) ||
                        bus.out_last !== (beat == N - 1)) begin
                        errors++;
                        $display("FAIL %s pos[%0d]: got row=%0d col=%0d last=%b expected %0d %0d %b",
                                 name, beat, bus.out_row, bus.out_col, bus.out_last, beat / 8,
                                 beat % 8, beat == N - 1);
                    end
                    if (beat == 0) first_n = n;
                    if (beat == N - 1) last_n = n;
                    beat++;
                end
            end
            #1;
            if (bus.c_rd_en === 1'b1) begin
                checks++;
                if (int'(bus.c_addr) > beat + 2) begin
                    errors++;
                    $display("FAIL %s addr_ahead: c_addr=%0d expected <= %0d", name, bus.c_addr,
                             beat + 2);
                end
            end
            if (beat >= stop_beat && (stop_beat < N || n >= last_n + 3)) break;
        end
        checks++;
        if (beat < stop_beat) begin
            errors++;
            $display("FAIL %s timeout: got %0d words expected %0d", name, beat, stop_beat);
        end
        if (stop_beat == N) begin
            checks++;
            if (fd_cnt !== 1 || fd_n !== last_n + 1) begin
                errors++;
                $display("FAIL %s frame_done: got %0d pulses at cycle %0d expected 1 at %0d",
                         name, fd_cnt, fd_n, last_n + 1);
            end
            if (timing) begin
                checks++;
                if (first_n !== 3 || last_n !== 66) begin
                    errors++;
                    $display("FAIL %s beat_timing: got first=%0d last=%0d expected 3 66",
                             name, first_n, last_n);
                end
            end
        end
    endtask

    task automatic check_quiet(input string name);
        logic [31:0] v;
        v = {bus.out_valid, bus.c_rd_en, bus.c_addr, bus.out_data, bus.out_sat, bus.out_last,
             frame_done, busy, 2'b00};
        checks++;
        if (v !== 32'd0 || bus.out_row !== 3'd0 || bus.out_col !== 3'd0) begin
            errors++;
            $display("FAIL %s: outputs=%h row=%0d col=%0d expected all 0", name, v, bus.out_row,
                     bus.out_col);
        end
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset_values");
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_quiet("idle_after_reset");
    endtask

    task automatic test_abort();
        int fd = 0;
        fill_mem(1);
        run_frame("abort_pre", 0, 0, 20);
        done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.c_rd_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: valid=%b rd_en=%b busy=%b expected 0 0 0",
                     bus.out_valid, bus.c_rd_en, busy);
        end
        for (int i = 0; i < 5; i++) begin
            if (frame_done === 1'b1) fd++;
            @(negedge clk);
        end
        checks++;
        if (fd !== 0) begin
            errors++;
            $display("FAIL abort_no_frame_done: got %0d pulses expected 0", fd);
        end
        run_frame("abort_restart", 0, 1, N);
    endtask

    task automatic test_reset_mid_frame();
        int seen = 0;
        fill_mem(1);
        run_frame("reset_pre", 2, 0, 40);
        #2 reset = 1'b0;
        #1 check_quiet("reset_mid_frame");
        done = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.c_rd_en !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_stays_idle: got %0d active cycles expected 0", seen);
        end
        run_frame("reset_restart", 0, 1, N);
    endtask

    task automatic test_back_to_back();
        fill_mem(1);
        run_frame("b2b_first", 0, 1, N);
        fill_mem(1);
        run_frame("b2b_second", 0, 1, N);
    endtask

    initial begin
        test_reset();
        fill_mem(0);
        run_frame("incrementing", 0, 1, N);
        fill_mem(1);
        run_frame("saturation", 0, 1, N);
        fill_mem(1);
        run_frame("backpressure", 1, 0, N);
        fill_mem(1);
        run_frame("random_ready", 2, 0, N);
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
